vend_credit_fsm: RTL and testbench

VEND_CREDIT_FSM -- requirements
Module: vend_credit_fsm

---
 rtl/vend_credit_fsm.sv | 89 ++++++++
 tb/tb_vend_credit_fsm.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/vend_credit_fsm.sv
// vend_credit_fsm: coin-credit vending controller with auto-vend, optional change return and sales counter.
module vend_credit_fsm #(
    parameter int CREDIT_W    = 4,
    parameter int PRICE       = 4,
    parameter int MAX_CREDIT  = 15,
    parameter int COIN1_VAL   = 1,
    parameter int COIN2_VAL   = 3,
    parameter int COIN3_VAL   = 5,
    parameter int AUTO_CHANGE = 1,
    parameter int CNT_W       = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                coinInserted,
    input  logic [1:0]          CoinValue,
    input  logic                refund,
    output logic                drop,
    output logic                changeOut,
    output logic                coinReject,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy,
    output logic [CNT_W-1:0]    saleCount
);
    localparam logic [CREDIT_W:0] PRICE_X = (CREDIT_W+1)'(PRICE);
    localparam logic [CREDIT_W:0] MAX_X   = (CREDIT_W+1)'(MAX_CREDIT);
    localparam logic [CREDIT_W:0] C1_X    = (CREDIT_W+1)'(COIN1_VAL);
    localparam logic [CREDIT_W:0] C2_X    = (CREDIT_W+1)'(COIN2_VAL);
    localparam logic [CREDIT_W:0] C3_X    = (CREDIT_W+1)'(COIN3_VAL);
    localparam logic [CREDIT_W:0] ONE_X   = (CREDIT_W+1)'(1);
    typedef enum logic [1:0] {IDLE, WAIT_REL, VEND, CHANGE} state_t;
    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                rej_q, rej_d;
    logic [CREDIT_W:0]   cred_x, coin_x, sum_x, rem_x, dec_x;
    // one extra bit keeps every sum and difference compare free of wrap-around
    assign cred_x = {1'b0, credit_q};
    assign coin_x = CoinValue == 2'd1 ? C1_X : CoinValue == 2'd2 ? C2_X : CoinValue == 2'd3 ? C3_X : '0;
    assign sum_x  = cred_x + coin_x;
    assign rem_x  = cred_x - PRICE_X;
    assign dec_x  = cred_x - ONE_X;
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            credit_q <= '0;
            cnt_q    <= '0;
            rej_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            cnt_q    <= cnt_d;
            rej_q    <= rej_d;
        end
    end
    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        cnt_d    = cnt_q;
        rej_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (coinInserted) begin
                    state_d = WAIT_REL;
                    if (sum_x <= MAX_X) credit_d = sum_x[CREDIT_W-1:0];
                    else rej_d = 1'b1;
                end else if (refund && credit_q != '0) begin
                    state_d = CHANGE;
                end
            end
            WAIT_REL: if (!coinInserted) state_d = cred_x >= PRICE_X ? VEND : IDLE;
            VEND: begin
                credit_d = rem_x[CREDIT_W-1:0];
                cnt_d    = cnt_q + CNT_W'(1);
                state_d  = rem_x >= PRICE_X ? VEND : (AUTO_CHANGE != 0 && rem_x != '0) ? CHANGE : IDLE;
            end
            CHANGE: begin
                credit_d = dec_x[CREDIT_W-1:0];
                state_d  = dec_x == '0 ? IDLE : CHANGE;
            end
            default: state_d = IDLE;
        endcase
    end
    assign drop       = state_q == VEND;
    assign changeOut  = state_q == CHANGE;
    assign busy       = drop | changeOut;
    assign coinReject = rej_q;
    assign credit     = credit_q;
    assign saleCount  = cnt_q;
endmodule

// File: tb/tb_vend_credit_fsm.sv
// tb_vend_credit_fsm: directed and random checks of two vend_credit_fsm configurations against a count-based model.
module tb_vend_credit_fsm;
    logic       clock = 1'b0;
    logic       reset = 1'b0, coinInserted = 1'b0, refund = 1'b0;
    logic [1:0] CoinValue = 2'd0;
    logic [1:0] drop_w, chg_w, rej_w, busy_w;
    logic [3:0] cred_w [2];
    logic [7:0] sc_w [2];
    int n_tests = 0, n_fail = 0;
    int m_cred[2], m_nv[2], m_nc[2], m_sales[2], m_wait[2], m_rej[2];
    always #5 clock = ~clock;
    vend_credit_fsm u_dut0 (
        .clock(clock), .reset(reset), .coinInserted(coinInserted), .CoinValue(CoinValue), .refund(refund),
        .drop(drop_w[0]), .changeOut(chg_w[0]), .coinReject(rej_w[0]), .credit(cred_w[0]),
        .busy(busy_w[0]), .saleCount(sc_w[0])
    );
    vend_credit_fsm #(.MAX_CREDIT(7), .AUTO_CHANGE(0)) u_dut1 (
        .clock(clock), .reset(reset), .coinInserted(coinInserted), .CoinValue(CoinValue), .refund(refund),
        .drop(drop_w[1]), .changeOut(chg_w[1]), .coinReject(rej_w[1]), .credit(cred_w[1]),
        .busy(busy_w[1]), .saleCount(sc_w[1])
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    // The model turns a release into whole vend/change counts by division and then just counts them down.
    task automatic step(input logic r, input logic c, input logic [1:0] v, input logic f);
        reset = r; coinInserted = c; CoinValue = v; refund = f;
        @(posedge clock);
        for (int k = 0; k < 2; k++) begin
            int maxc, autoc, cv;
            maxc  = k ? 7 : 15;
            autoc = k ? 0 : 1;
            cv    = v == 2'd1 ? 1 : v == 2'd2 ? 3 : v == 2'd3 ? 5 : 0;
            if (r) begin
                m_cred[k] = 0; m_nv[k] = 0; m_nc[k] = 0; m_sales[k] = 0; m_wait[k] = 0; m_rej[k] = 0;
            end else begin
                m_rej[k] = 0;
                if (m_nv[k] > 0) begin
                    m_cred[k] -= 4; m_nv[k]--; m_sales[k] = (m_sales[k] + 1) % 256;
                end else if (m_nc[k] > 0) begin
                    m_cred[k]--; m_nc[k]--;
                end else if (m_wait[k] != 0) begin
                    if (!c) begin
                        m_wait[k] = 0;
                        if (m_cred[k] >= 4) begin
                            m_nv[k] = m_cred[k] / 4;
                            m_nc[k] = autoc ? m_cred[k] % 4 : 0;
                        end
                    end
                end else if (c) begin
                    m_wait[k] = 1;
                    if (m_cred[k] + cv <= maxc) m_cred[k] += cv;
                    else m_rej[k] = 1;
                end else if (f && m_cred[k] > 0) begin
                    m_nc[k] = m_cred[k];
                end
            end
        end
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("dut%0d drop", k), drop_w[k], m_nv[k] > 0);
            check($sformatf("dut%0d changeOut", k), chg_w[k], m_nv[k] == 0 && m_nc[k] > 0);
            check($sformatf("dut%0d busy", k), busy_w[k], m_nv[k] > 0 || m_nc[k] > 0);
            check($sformatf("dut%0d credit", k), cred_w[k], m_cred[k]);
            check($sformatf("dut%0d coinReject", k), rej_w[k], m_rej[k]);
            check($sformatf("dut%0d saleCount", k), sc_w[k], m_sales[k]);
        end
    endtask
    initial begin
        int nchg;
        logic c;
        step(1'b1, 1'($urandom), 2'($urandom), 1'($urandom));
        step(1'b1, 1'($urandom), 2'($urandom), 1'($urandom));
        check("rst credit", cred_w[0], 0);
        check("rst busy", busy_w[0], 0);
        check("rst saleCount", sc_w[0], 0);
        step(1'b1, 1'b0, 2'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 2'd1, 1'b0);
            check("ins01 credit", cred_w[0], i + 1);
            step(1'b0, 1'b0, 2'd0, 1'b0);
        end
        check("4x01 drop", drop_w[0], 1);
        step(1'b0, 1'b0, 2'd0, 1'b0);
        check("4x01 credit after", cred_w[0], 0);
        check("4x01 saleCount", sc_w[0], 1);
        check("4x01 no change", chg_w[0], 0);
        step(1'b0, 1'b1, 2'd3, 1'b0);
        check("ins11 credit", cred_w[0], 5);
        step(1'b0, 1'b0, 2'd0, 1'b0);
        check("ins11 drop", drop_w[0], 1);
        step(1'b0, 1'b0, 2'd0, 1'b0);
        check("ins11 change", chg_w[0], 1);
        check("ins11 credit left", cred_w[0], 1);
        step(1'b0, 1'b0, 2'd0, 1'b0);
        check("ins11 idle credit", cred_w[0], 0);
        step(1'b1, 1'b0, 2'd0, 1'b0);
        step(1'b0, 1'b1, 2'd2, 1'b0);
        step(1'b0, 1'b0, 2'd0, 1'b0);
        check("nochg credit 3", cred_w[1], 3);
        step(1'b0, 1'b1, 2'd3, 1'b0);
        check("nochg reject", rej_w[1], 1);
        check("nochg credit kept", cred_w[1], 3);
        step(1'b0, 1'b0, 2'd0, 1'b0);
        check("nochg reject once", rej_w[1], 0);
        step(1'b0, 1'b1, 2'd1, 1'b0);
        check("nochg credit 4", cred_w[1], 4);
        step(1'b0, 1'b0, 2'd0, 1'b0);
        check("nochg drop", drop_w[1], 1);
        step(1'b0, 1'b0, 2'd0, 1'b0);
        check("nochg credit 0", cred_w[1], 0);
        step(1'b1, 1'b0, 2'd0, 1'b0);
        step(1'b0, 1'b1, 2'd2, 1'b0);
        step(1'b0, 1'b0, 2'd0, 1'b0);
        nchg = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0, 2'd0, 1'b1);
            nchg += int'(chg_w[0]);
        end
        check("refund change count", nchg, 3);
        check("refund credit", cred_w[0], 0);
        step(1'b0, 1'b1, 2'd2, 1'b0);
        step(1'b0, 1'b0, 2'd0, 1'b0);
        step(1'b0, 1'b0, 2'd0, 1'b1);
        step(1'b0, 1'b0, 2'd0, 1'b0);
        check("mid-change busy", busy_w[0], 1);
        step(1'b1, 1'b0, 2'd0, 1'b0);
        check("rst mid-change credit", cred_w[0], 0);
        check("rst mid-change changeOut", chg_w[0], 0);
        step(1'b0, 1'b1, 2'd1, 1'b0);
        step(1'b1, 1'b1, 2'd1, 1'b0);
        check("rst wait credit", cred_w[0], 0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 2'd1, 1'b0);
        check("held coin once", cred_w[0], 1);
        step(1'b0, 1'b0, 2'd0, 1'b0);
        c = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) c = ~c;
            step($urandom_range(0, 99) == 0, c, 2'($urandom_range(0, 3)), $urandom_range(0, 7) == 0);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
